mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//   Multi-cycle multiply/divide sequencer that sits beside the single-cycle ALU in the EX stage.
//   Executes MULT/MULTU/DIV/DIVU iteratively: one bit per cycle, with an internal 33-bit add/sub.
//   Owns the HI/LO architectural registers, including the MTHI/MTLO writes.
//   The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//   clk      in   1      system clock, rising edge
//   reset    in   1      synchronous reset, active-low
//   start    in   1      launch op; sampled only in IDLE
//   op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a        in   WIDTH  multiplicand / dividend (rs)
//   b        in   WIDTH  multiplier / divisor (rt)
//   wr_hi    in   1      MTHI write strobe
//   wr_lo    in   1      MTLO write strobe
//   wdata    in   WIDTH  MTHI/MTLO data
//   busy     out  1      high from the cycle after start is accepted until done
//   done     out  1      one-cycle completion pulse
//   div_zero out  1      valid with done: divide by zero occurred
//   hi       out  WIDTH  HI register (product high / remainder)
//   lo       out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//   Reset (reset==0 at clk edge):
//     - state=IDLE, counter=0
//     - busy, done, div_zero = 0
//     - hi = lo = 0
//     - Reset mid-operation discards the op.
//   FSM: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: start==1 latches a, b, op and goes to PREP. start is ignored in every other state.
//   PREP:
//     - Signed ops (op[0]==1): take operand magnitudes; record result signs.
//       * MULT: product sign = a[31]^b[31].
//       * DIV: quotient sign = a[31]^b[31]; remainder sign = a[31].
//     - DIV/DIVU with b==0: go straight to DONE, set div_zero=1, leave hi/lo unchanged.
//     - Otherwise load counter=WIDTH-1 and go to RUN.
//   RUN: exactly WIDTH cycles, one bit per cycle.
//     - Multiply: shift-add into a 2*WIDTH accumulator.
//     - Divide: restoring; 33-bit trial subtract per bit.
//     - Counter decrements each cycle; at 0 go to FIX.
//   FIX:
//     - Negate the result (64-bit two's complement) where the recorded sign requires it.
//     - Register {hi,lo} at the end of the cycle.
//     - MULT*: {hi,lo} = full 2*WIDTH product.
//     - DIV*: lo = quotient (truncated toward zero); hi = remainder (sign of dividend).
//     - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
//   DONE: done=1 for this cycle only; busy=0 in this cycle; return to IDLE.
//   Latency (start sampled in cycle 0):
//     - Normal op: done in cycle WIDTH+3 = 35.
//     - Divide by zero: done in cycle 2.
//   busy is high in PREP, RUN and FIX.
//   div_zero is only meaningful while done==1; it is cleared when the next op is accepted.
//   MTHI/MTLO:
//     - Applied at the clock edge only while in IDLE or DONE.
//     - Ignored in PREP, RUN and FIX; the pipeline guarantees stall.
//     - wr_hi and wr_lo in the same cycle: both registers are written.
//     - start and wr_hi/wr_lo in the same IDLE cycle: the write takes effect, and the op result overwrites it at FIX.
//   Arithmetic is modulo 2^WIDTH per register. No overflow flag is produced.
// CONFIGURATION
//   MDU_ABORT_EN:
//     - Defined: adds port "abort in 1" (pipeline flush on exception).
//     - abort==1 in PREP, RUN or FIX returns to IDLE next cycle.
//     - On abort: no done pulse; hi/lo keep their pre-op values, so the FIX write is suppressed.
//     - abort in IDLE or DONE has no effect.
//     - Not defined: no abort port; an op always runs to completion.
// TESTING
//   1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 35; hi=0xFFFFFFFE, lo=0x00000001, div_zero=0.
//   2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
//   3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. Preload via MTHI=0x11, MTLO=0x22; then DIVU a=5 b=0 -> done in cycle 2, div_zero=1, hi=0x11, lo=0x22.
//   5. DIVU 100/7 running -> start and wr_hi pulsed during RUN are ignored; lo=14, hi=2.
//      Second run: reset=0 at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done.
//   6. MDU_ABORT_EN defined: MULTU 3*4 over prior hi/lo=0/0x22, abort in RUN -> IDLE next cycle; no done; lo stays 0x22.

Source files
------------

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- multi-cycle multiply/divide sequencer for the EX stage.
//
// Runs MULTU/MULT/DIVU/DIV one bit per cycle through a (WIDTH+1)-bit add/sub.
// It owns the architectural HI/LO registers, including MTHI/MTLO writes.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous reset, active-low
//   start      in   1      launch an op (only looked at in IDLE)
//   op         in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a          in   WIDTH  multiplicand / dividend (rs)
//   b          in   WIDTH  multiplier / divisor (rt)
//   wr_hi      in   1      MTHI write strobe
//   wr_lo      in   1      MTLO write strobe
//   wdata      in   WIDTH  MTHI/MTLO write data
//   abort      in   1      pipeline flush (only when MDU_ABORT_EN is defined)
//   busy       out  1      op in flight (PREP, RUN, FIX)
//   done       out  1      one-cycle completion pulse
//   div_zero   out  1      qualifies done: the op was a divide by zero
//   hi         out  WIDTH  HI register (product high / remainder)
//   lo         out  WIDTH  LO register (product low / quotient)
//   dbg_state  out  3      current FSM state, for checkers and debug
//
// Configuration macro
//   MDU_ABORT_EN  adds the abort port; abort in PREP/RUN/FIX drops the op
//                 with no done pulse and no HI/LO update.
//
// Handshake: start is taken only in IDLE, whatever busy says. busy rises the
// cycle after acceptance and stays high through FIX. done pulses for one cycle
// in DONE with busy low, and hi/lo/div_zero are valid in that cycle. The
// pipeline stalls on busy, so start is never accepted with busy high.
// -----------------------------------------------------------------------------
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;      // {upper, lower} working accumulator
  logic [CW-1:0]      cnt_q;
  logic               neg_p_q;    // negate product / quotient at FIX
  logic               neg_r_q;    // negate remainder at FIX
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               abort_w;

`ifdef MDU_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: operand magnitudes, one iteration step, final sign fix-up
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [WIDTH:0]     add_d;
  logic [2*WIDTH-1:0] mul_next_d;
  logic [WIDTH:0]     shl_d;
  logic [WIDTH:0]     trial_d;
  logic [2*WIDTH-1:0] div_next_d;
  logic [2*WIDTH-1:0] prod_neg_d;
  logic [WIDTH-1:0]   q_neg_d;
  logic [WIDTH-1:0]   r_neg_d;
  logic [WIDTH-1:0]   hi_fix_d;
  logic [WIDTH-1:0]   lo_fix_d;

  always_comb begin
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    a_mag_d = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag_d = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;

    // Shift-add multiply: the multiplier sits in the low half and is
    // consumed from bit 0 while the partial product grows into the top.
    add_d      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next_d = {add_d, acc_q[WIDTH-1:1]};

    // Restoring divide: remainder in the top half, dividend bits shift out
    // of the low half while quotient bits shift in. The shifted remainder
    // is below 2*divisor, so bit WIDTH of the trial difference is a clean
    // borrow flag.
    shl_d      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial_d    = shl_d - {1'b0, opnd_q};
    div_next_d = trial_d[WIDTH] ? {shl_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {trial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_neg_d = -acc_q;
    q_neg_d    = -acc_q[WIDTH-1:0];
    r_neg_d    = -acc_q[2*WIDTH-1:WIDTH];

    if (op_q[1]) begin
      lo_fix_d = neg_p_q ? q_neg_d : acc_q[WIDTH-1:0];
      hi_fix_d = neg_r_q ? r_neg_d : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      lo_fix_d = neg_p_q ? prod_neg_d[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      hi_fix_d = neg_p_q ? prod_neg_d[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer and HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_hi) hi_q <= wdata;
          if (wr_lo) lo_q <= wdata;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end

        S_PREP: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            neg_p_q <= op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_r_q <= op_q[0] & op_q[1] & a_q[WIDTH-1];
            if (op_q[1] && (b_q == '0)) begin
              // Divide by zero skips the iteration and leaves HI/LO alone.
              dz_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              opnd_q  <= op_q[1] ? b_mag_d : a_mag_d;
              acc_q   <= {{WIDTH{1'b0}}, (op_q[1] ? a_mag_d : b_mag_d)};
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= op_q[1] ? div_next_d : mul_next_d;
            if (cnt_q == '0) begin
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end

        S_FIX: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hi_q    <= hi_fix_d;
            lo_q    <= lo_fix_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          if (wr_hi) hi_q <= wdata;
          if (wr_lo) lo_q <= wdata;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_seq.sv
// -----------------------------------------------------------------------------
// tb_mdu_seq -- self-checking bench for mdu_seq.
// Directed cases for the documented corner results plus randomized ops, all
// checked against an arithmetic model of HI/LO kept in this file.
// -----------------------------------------------------------------------------
module tb_mdu_seq;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [2:0]   dbg_state;
`ifdef MDU_ABORT_EN
  logic         abort;
`endif

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .wdata     (wdata),
`ifdef MDU_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic [2*W:0] exp_q[$];   // {div_zero, hi, lo}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one op given the current HI/LO model.
  function automatic logic [2*W:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [63:0]        p;
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sx = $signed({{32{x[W-1]}}, x});
    sy = $signed({{32{y[W-1]}}, y});
    p  = '0;
    if (o[1] && y == '0) return {1'b1, m_hi, m_lo};
    case (o)
      2'b00: p = {32'b0, x} * {32'b0, y};
      2'b01: p = sx * sy;
      2'b10: p = {x % y, x / y};
      default: begin
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
      end
    endcase
    return {1'b0, p};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic mt_write(input bit h, input bit l, input logic [W-1:0] v);
    wr_hi = h;
    wr_lo = l;
    wdata = v;
    tick;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  // poke: disturb the DUT mid-run and during DONE (must be ignored / only the
  // DONE-cycle MTHI takes effect). wr_same: MTLO in the launch cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke, input bit wr_same, input logic [W-1:0] wv);
    logic [2*W:0] e;
    int           n;
    int           lat;
    bit           seen;
    if (wr_same) begin
      wr_lo = 1'b1;
      wdata = wv;
      m_lo  = wv;
    end
    exp_q.push_back(ref_op(o, x, y));
    lat   = (o[1] && y == '0) ? 2 : W + 3;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 100) begin
      tick;
      n++;
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      if (n == 1) check("busy_after_start", 64'(busy), 64'(1));
      if (poke && n == 10) begin
        start = 1'b1;
        op    = 2'b01;
        a     = $urandom;
        b     = $urandom;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      if (done) seen = 1'b1;
    end
    check("latency", 64'(n), 64'(lat));
    e = exp_q.pop_front();
    check("busy_at_done", 64'(busy), 64'(0));
    check("div_zero", 64'(div_zero), 64'(e[2*W]));
    check("hi", 64'(hi), 64'(e[2*W-1:W]));
    check("lo", 64'(lo), 64'(e[W-1:0]));
    m_hi = e[2*W-1:W];
    m_lo = e[W-1:0];
    if (poke) begin
      start = 1'b1;
      op    = 2'b00;
      wr_hi = 1'b1;
      wdata = wv;
      m_hi  = wv;
    end
    tick;
    start = 1'b0;
    wr_hi = 1'b0;
    check("done_pulse", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("hi_after", 64'(hi), 64'(m_hi));
    check("lo_after", 64'(lo), 64'(m_lo));
  endtask

  task automatic reset_mid(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit saw_done;
    op       = o;
    a        = x;
    b        = y;
    start    = 1'b1;
    saw_done = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick;
      start = 1'b0;
    end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    m_hi  = '0;
    m_lo  = '0;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_hi", 64'(hi), 64'(0));
    check("rst_mid_lo", 64'(lo), 64'(0));
    for (int n = 0; n < 40; n++) begin
      tick;
      if (done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", 64'(saw_done), 64'(0));
  endtask

`ifdef MDU_ABORT_EN
  task automatic abort_run;
    bit saw_done;
    saw_done = 1'b0;
    mt_write(1'b1, 1'b1, 32'h0);
    mt_write(1'b0, 1'b1, 32'h22);
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd4;
    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick;
      start = 1'b0;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    for (int n = 0; n < 40; n++) begin
      tick;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'(0));
    check("abort_hi", 64'(hi), 64'(m_hi));
    check("abort_lo", 64'(lo), 64'(32'h22));
  endtask
`endif

  function automatic logic [W-1:0] pick_val;
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = '0;
`ifdef MDU_ABORT_EN
    abort = 1'b0;
`endif
    m_hi  = '0;
    m_lo  = '0;
    tick;
    tick;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    tick;

    // Documented corner results
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, '0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, '0);
    run_op(2'b10, 32'd100, 32'd7, 1'b1, 1'b0, 32'h5555_AAAA);
    reset_mid(2'b10, 32'd100, 32'd7);

    // MTLO in the launch cycle: kept on divide by zero, overwritten otherwise
    run_op(2'b11, 32'd9, 32'd0, 1'b0, 1'b1, 32'h33);
    run_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b1, 32'h44);
    mt_write(1'b1, 1'b1, 32'h1234_5678);

`ifdef MDU_ABORT_EN
    abort_run;
`endif

    // Randomized ops with occasional MTHI/MTLO in between
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(2'($urandom_range(0, 3)), pick_val(), pick_val(),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
